ex_muldiv: RTL and testbench



---
 rtl/ex_muldiv.sv | 161 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ex_muldiv : EX-stage multi-cycle multiply/divide unit owning HI/LO.        |
// | Optional MULDIV_MADD_EN enables madd/maddu/msub/msubu accumulate ops.      |
// | The MEM-stage kill input is named md_disable ("disable" is a keyword).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ex_muldiv #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_disable,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int c_CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_MULT_LD  = c_CNT_W'(MULT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_DIV_LD   = c_CNT_W'(DIV_CYCLES);

  localparam logic [3:0] c_OP_MULT  = 4'd1;
  localparam logic [3:0] c_OP_MULTU = 4'd2;
  localparam logic [3:0] c_OP_DIV   = 4'd3;
  localparam logic [3:0] c_OP_DIVU  = 4'd4;
  localparam logic [3:0] c_OP_MTHI  = 4'd5;
  localparam logic [3:0] c_OP_MTLO  = 4'd6;
`ifdef MULDIV_MADD_EN
  localparam logic [3:0] c_OP_MADD  = 4'd7;
  localparam logic [3:0] c_OP_MADDU = 4'd8;
  localparam logic [3:0] c_OP_MSUB  = 4'd9;
  localparam logic [3:0] c_OP_MSUBU = 4'd10;
`endif

  logic [c_CNT_W-1:0] r_count;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_temp_hi;
  logic [31:0]        r_temp_lo;

  logic               w_op_valid;
  logic               w_accept;
  logic               w_mul_signed;
  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic [63:0]        w_prod;
  logic               w_div_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [31:0]        w_a_mag;
  logic [31:0]        w_b_mag;
  logic [31:0]        w_q_mag;
  logic [31:0]        w_r_mag;
  logic [31:0]        w_quot;
  logic [31:0]        w_rem;

  always_comb begin
    w_op_valid = 1'b0;
    case (op)
      c_OP_MULT, c_OP_MULTU, c_OP_DIV, c_OP_DIVU, c_OP_MTHI, c_OP_MTLO: w_op_valid = 1'b1;
`ifdef MULDIV_MADD_EN
      c_OP_MADD, c_OP_MADDU, c_OP_MSUB, c_OP_MSUBU: w_op_valid = 1'b1;
`endif
      default: w_op_valid = 1'b0;
    endcase
  end

  assign w_accept = start && w_op_valid && !busy && !md_disable;

`ifdef MULDIV_MADD_EN
  assign w_mul_signed = (op == c_OP_MULT) || (op == c_OP_MADD) || (op == c_OP_MSUB);
`else
  assign w_mul_signed = (op == c_OP_MULT);
`endif

  assign w_prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};
  assign w_prod   = w_mul_signed ? w_prod_s : w_prod_u;

  // Divide on magnitudes so 0x80000000 / -1 wraps cleanly instead of trapping.
  assign w_div_signed = (op == c_OP_DIV);
  assign w_a_neg      = w_div_signed && rs_val[31];
  assign w_b_neg      = w_div_signed && rt_val[31];
  assign w_a_mag      = w_a_neg ? (32'd0 - rs_val) : rs_val;
  assign w_b_mag      = w_b_neg ? (32'd0 - rt_val) : rt_val;
  assign w_q_mag      = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag / w_b_mag);
  assign w_r_mag      = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag % w_b_mag);
  assign w_quot       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem        = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

`ifdef MULDIV_MADD_EN
  logic [63:0] w_acc;
  assign w_acc = {r_hi, r_lo};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= c_CNT_ZERO;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_temp_hi <= 32'd0;
      r_temp_lo <= 32'd0;
    end else if (r_count != c_CNT_ZERO) begin
      r_count <= r_count - c_CNT_ONE;
      if (r_count == c_CNT_ONE) begin
        r_hi <= r_temp_hi;
        r_lo <= r_temp_lo;
      end
    end else if (w_accept) begin
      case (op)
        c_OP_MULT, c_OP_MULTU: begin
          {r_temp_hi, r_temp_lo} <= w_prod;
          r_count                <= c_MULT_LD;
        end
        c_OP_DIV, c_OP_DIVU: begin
          // Divide by zero re-commits the current HI/LO, leaving them unchanged.
          if (rt_val == 32'd0) begin
            r_temp_hi <= r_hi;
            r_temp_lo <= r_lo;
          end else begin
            r_temp_hi <= w_rem;
            r_temp_lo <= w_quot;
          end
          r_count <= c_DIV_LD;
        end
        c_OP_MTHI: r_hi <= rs_val;
        c_OP_MTLO: r_lo <= rs_val;
`ifdef MULDIV_MADD_EN
        c_OP_MADD, c_OP_MADDU: begin
          {r_temp_hi, r_temp_lo} <= w_acc + w_prod;
          r_count                <= c_MULT_LD;
        end
        c_OP_MSUB, c_OP_MSUBU: begin
          {r_temp_hi, r_temp_lo} <= w_acc - w_prod;
          r_count                <= c_MULT_LD;
        end
`endif
        default: ;
      endcase
    end
  end

  assign busy  = (r_count != c_CNT_ZERO);
  assign stall = d_uses_md && (busy || start);
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// Bench for ex_muldiv: vector table through a scoreboard, then hand-written
// sequences for mthi/mtlo, disable, start-while-busy, stall and mid-op reset.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        reset, start, md_disable, d_uses_md;
  logic [3:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  ex_muldiv #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .md_disable(md_disable),
    .d_uses_md(d_uses_md), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          lat;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  typedef struct {
    int          lat;
    logic [31:0] eh;
    logic [31:0] el;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                              input int lat, input logic [31:0] eh, input logic [31:0] el);
    vec_t v;
    v.op = o; v.rs = a; v.rt = b; v.lat = lat; v.eh = eh; v.el = el;
    vecs.push_back(v);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch one op, push its expectation, wait out busy and score the result.
  task automatic run_op(input string nm, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] eh,
                        input logic [31:0] el);
    exp_t e;
    int   cnt;
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    e.lat = lat; e.eh = eh; e.el = el;
    sb.push_back(e);
    tick();
    start = 1'b0; op = 4'd0;
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      tick();
    end
    e = sb.pop_front();
    chk({nm, " latency"}, 64'(cnt), 64'(e.lat));
    chk({nm, " hi:lo"}, {hi, lo}, {e.eh, e.el});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  cnt;
    bit  all_stall;

    add(4'd1,  32'hFFFFFFFF, 32'd2,        5,  32'hFFFFFFFF, 32'hFFFFFFFE);
    add(4'd2,  32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE);
    add(4'd3,  32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    add(4'd4,  32'd7,        32'd0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    add(4'd3,  32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
    add(4'd4,  32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E);
    add(4'd3,  32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
    add(4'd1,  32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'h00000000, 32'h00000001);
    add(4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001);
    add(4'd1,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000);
    add(4'd5,  32'h00001234, 32'd0,        0,  32'h00001234, 32'h00000000);
    add(4'd6,  32'h00005678, 32'd0,        0,  32'h00001234, 32'h00005678);
    add(4'd0,  32'hAAAAAAAA, 32'd3,        0,  32'h00001234, 32'h00005678);
    add(4'd11, 32'hAAAAAAAA, 32'd3,        0,  32'h00001234, 32'h00005678);
`ifdef MULDIV_MADD_EN
    add(4'd5,  32'd0,        32'd0,        0,  32'h00000000, 32'h00005678);
    add(4'd6,  32'd5,        32'd0,        0,  32'h00000000, 32'h00000005);
    add(4'd7,  32'd3,        32'd4,        5,  32'h00000000, 32'h00000011);
    add(4'd10, 32'd1,        32'd20,       5,  32'hFFFFFFFF, 32'hFFFFFFFD);
    add(4'd9,  32'd2,        32'hFFFFFFFF, 5,  32'hFFFFFFFF, 32'hFFFFFFFF);
    add(4'd8,  32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFD);
`else
    add(4'd7,  32'd3,        32'd4,        0,  32'h00001234, 32'h00005678);
    add(4'd10, 32'd1,        32'd20,       0,  32'h00001234, 32'h00005678);
`endif

    reset = 1'b1; start = 1'b0; md_disable = 1'b0; d_uses_md = 1'b0;
    op = 4'd0; rs_val = 32'd0; rt_val = 32'd0;
    tick(); tick();
    reset = 1'b0;
    chk("reset hi:lo", {hi, lo}, 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset stall", 64'(stall), 64'd0);

    for (int i = 0; i < vecs.size(); i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
             vecs[i].lat, vecs[i].eh, vecs[i].el);

    // mthi then mtlo on consecutive cycles
    start = 1'b1; op = 4'd5; rs_val = 32'h1234;
    tick();
    chk("mthi busy", 64'(busy), 64'd0);
    op = 4'd6; rs_val = 32'h5678;
    tick();
    start = 1'b0; op = 4'd0;
    chk("mtlo busy", 64'(busy), 64'd0);
    chk("mthi/mtlo hi:lo", {hi, lo}, 64'h00001234_00005678);

    // mult killed by disable in its start cycle
    start = 1'b1; op = 4'd1; rs_val = 32'hFFFFFFFF; rt_val = 32'd2; md_disable = 1'b1;
    tick();
    start = 1'b0; op = 4'd0; md_disable = 1'b0;
    chk("disabled mult busy", 64'(busy), 64'd0);
    tick();
    chk("disabled mult hi:lo", {hi, lo}, 64'h00001234_00005678);

    // disable two cycles into an accepted div does not abort it
    start = 1'b1; op = 4'd4; rs_val = 32'd100; rt_val = 32'd7;
    tick();
    start = 1'b0; op = 4'd0;
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      md_disable = (cnt == 2);
      tick();
    end
    md_disable = 1'b0;
    chk("div+disable latency", 64'(cnt), 64'd10);
    chk("div+disable hi:lo", {hi, lo}, 64'h00000002_0000000E);

    // start while busy must be ignored
    start = 1'b1; op = 4'd1; rs_val = 32'd3; rt_val = 32'd4;
    tick();
    op = 4'd5; rs_val = 32'hDEAD;
    tick();
    start = 1'b0; op = 4'd0;
    chk("busy-start hi", 64'(hi), 64'h00000002);
    cnt = 1;
    while (busy && cnt < 200) begin
      cnt++;
      tick();
    end
    chk("busy-start latency", 64'(cnt), 64'd5);
    chk("busy-start hi:lo", {hi, lo}, 64'h00000000_0000000C);

    // stall covers the start cycle and every busy cycle, drops after commit
    d_uses_md = 1'b1;
    #1;
    chk("idle stall", 64'(stall), 64'd0);
    start = 1'b1; op = 4'd3; rs_val = 32'hFFFFFFF9; rt_val = 32'd2;
    #1;
    chk("start-cycle stall", 64'(stall), 64'd1);
    tick();
    start = 1'b0; op = 4'd0;
    cnt = 0;
    all_stall = 1'b1;
    while (busy && cnt < 200) begin
      cnt++;
      if (!stall) all_stall = 1'b0;
      tick();
    end
    chk("busy stall", 64'(all_stall), 64'd1);
    chk("post-commit stall", 64'(stall), 64'd0);
    chk("stall div hi:lo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    // reset in busy cycle 4 of a div clears everything, no commit
    start = 1'b1; op = 4'd4; rs_val = 32'd100; rt_val = 32'd7;
    tick();
    start = 1'b0; op = 4'd0;
    cnt = 1;
    while (cnt < 4) begin
      cnt++;
      tick();
    end
    chk("pre-reset busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid-op reset busy", 64'(busy), 64'd0);
    chk("mid-op reset hi:lo", {hi, lo}, 64'd0);
    chk("mid-op reset stall", 64'(stall), 64'd0);
    d_uses_md = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick(); tick();
    chk("no late commit hi:lo", {hi, lo}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
